// File: rtl/zigma_control_fsm.sv
// Zigma RV32I multi-cycle control sequencer (FETCH/DECODE/EXECUTE/MEM/WB/TRAP).
// In: clk, rst_n, instr (IR), imem_ready, dmem_ready, branch_taken.
// Out: imem_req, ir_en, pc_en, pc_sel, alu_src_a/b, alu_op, dmem_req/we,
//      reg_we, wb_sel, trap, trap_cause, retired.
module zigma_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [6:0] opcode;
    logic       rd_nz;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic       is_load, is_store, is_opimm, is_op, is_fence;
    logic       is_legal;
    logic [7:0] tmo_inc;
    logic [1:0] ex_src_a;
    logic       ex_src_b;
    logic [1:0] ex_op;
    logic       unused_instr;

    assign opcode    = instr[6:0];
    assign rd_nz     = (instr[11:7] != 5'd0);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_fence  = (opcode == OPC_FENCE);
    // Every legal opcode ends in 2'b11, so compressed encodings fall out here.
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr
                     | is_branch | is_load | is_store
                     | is_opimm | is_op | is_fence;
    assign tmo_inc   = tmo_q + 8'd1;
    assign unused_instr = ^instr[31:12];

    // ALU selectors chosen in EXECUTE; MEM and JALR's WB re-present them
    // so the address / target stays stable while the cycle completes.
    always_comb begin
        ex_src_a = 2'b00;
        ex_src_b = 1'b0;
        ex_op    = 2'b00;
        unique case (1'b1)
            is_op: begin
                ex_op = 2'b01;
            end
            is_opimm: begin
                ex_src_b = 1'b1;
                ex_op    = 2'b01;
            end
            is_lui: begin
                ex_src_a = 2'b10;
                ex_src_b = 1'b1;
            end
            is_auipc: begin
                ex_src_a = 2'b01;
                ex_src_b = 1'b1;
            end
            is_load, is_store, is_jalr: begin
                ex_src_b = 1'b1;
            end
            is_branch: begin
                ex_op = 2'b10;
            end
            default: begin
                ex_op = 2'b00;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                    tmo_d   = '0;
                end else if (tmo_inc == TMO_LIM) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end
            end
            S_EXECUTE: begin
                alu_src_a = ex_src_a;
                alu_src_b = ex_src_b;
                alu_op    = ex_op;
                if (is_branch || is_fence) begin
                    pc_en     = 1'b1;
                    pc_sel    = (is_branch && branch_taken)
                              ? 2'b01 : 2'b00;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = is_store;
                alu_src_a = ex_src_a;
                alu_src_b = ex_src_b;
                alu_op    = ex_op;
                if (dmem_ready) begin
                    tmo_d = '0;
                    if (is_store) begin
                        pc_en     = 1'b1;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_inc == TMO_LIM) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WB: begin
                reg_we = rd_nz;
                if (is_load) begin
                    wb_sel = 2'b01;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'b10;
                end
                if (is_jal) begin
                    pc_sel = 2'b01;
                end else if (is_jalr) begin
                    pc_sel    = 2'b10;
                    alu_src_a = ex_src_a;
                    alu_src_b = ex_src_b;
                    alu_op    = ex_op;
                end
                pc_en     = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule
